pc_predictor: RTL and testbench

Fetch-stage program counter generator with a parametrised direct-mapped BTB, per-entry N-bit saturating direction counters, entry typing (conditional, jump, call, return) and a small return-address stack (RAS). Each cycle it holds the current fetch `pc` and its prediction, and advances to the predicted target, `pc + 4`, or a redirect. It sits at the head of the pipeline. It is fed by execute-stage resolution (redirect and update) and by the stall controller.

---
 rtl/pc_predictor_pkg.sv | 14 +
 rtl/pc_predictor_ras_stack.sv | 45 ++++
 rtl/pc_predictor.sv | 122 ++++++++++++
 tb/tb_pc_predictor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_predictor_pkg.sv
// Shared control-flow type encodings and address constants for the fetch predictor.
package pc_predictor_pkg;

    typedef enum logic [1:0] {
        CT_COND = 2'b00,
        CT_JUMP = 2'b01,
        CT_CALL = 2'b10,
        CT_RET  = 2'b11
    } ctrl_type_e;

    localparam logic [31:0] Zero       = 32'h0000_0000;
    localparam logic [31:0] INSN_BYTES = 32'd4;

endpackage

// File: rtl/pc_predictor_ras_stack.sv
// Circular speculative return-address stack; a push when full overwrites the oldest entry.
module ras_stack
    import pc_predictor_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [31:0]              push_addr,
    input  logic                     pop,
    output logic [31:0]              top,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [31:0]   r_stack [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [PW:0]   r_count;
    logic [PW-1:0] w_top_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (push) begin
            r_stack[r_ptr] <= push_addr;
            r_ptr          <= r_ptr + 1'b1;
            if (r_count != FULL) begin
                r_count <= r_count + 1'b1;
            end
        end else if (pop && (r_count != '0)) begin
            r_ptr   <= r_ptr - 1'b1;
            r_count <= r_count - 1'b1;
        end
    end

    // r_ptr names the next free slot, so the top lives one below it.
    assign w_top_idx = r_ptr - 1'b1;
    assign top       = (r_count != '0) ? r_stack[w_top_idx] : Zero;
    assign count     = r_count;

endmodule

// File: rtl/pc_predictor.sv
// Fetch PC generator: direct-mapped BTB with saturating direction counters plus a speculative RAS.
module pc_predictor
    import pc_predictor_pkg::*;
#(
    parameter int unsigned IDX_BITS  = 7,
    parameter int unsigned TAG_BITS  = 9,
    parameter int unsigned CTR_BITS  = 2,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic [1:0]  upd_type,
    output logic [31:0] pc,
    output logic        pred_taken,
    output logic [31:0] pred_target
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam int unsigned CNT_W   = $clog2(RAS_DEPTH) + 1;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    logic                r_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];
    ctrl_type_e          r_type   [ENTRIES];
    logic [CTR_BITS-1:0] r_ctr    [ENTRIES];
    logic [31:0]         r_pc;

    logic [IDX_BITS-1:0] w_idx, w_uidx;
    logic [TAG_BITS-1:0] w_tag, w_utag;
    logic [31:0]         w_pc_plus4;
    logic                w_hit, w_uhit;
    ctrl_type_e          w_type;
    logic                w_advance;
    logic                w_ras_push, w_ras_pop;
    logic [31:0]         w_ras_top;
    logic [CNT_W-1:0]    w_ras_count;
    logic [CTR_BITS-1:0] w_new_ctr;

    assign w_idx      = r_pc[IDX_BITS+1:2];
    assign w_tag      = r_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign w_pc_plus4 = r_pc + INSN_BYTES;
    assign w_uidx     = upd_pc[IDX_BITS+1:2];
    assign w_utag     = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

    always_comb begin
        w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
        w_type      = r_type[w_idx];
        pred_taken  = 1'b0;
        pred_target = w_pc_plus4;
        if (w_hit) begin
            pred_taken = (w_type == CT_COND) ? r_ctr[w_idx][CTR_BITS-1] : 1'b1;
        end
        if (pred_taken) begin
            pred_target = ((w_type == CT_RET) && (w_ras_count != '0)) ? w_ras_top : r_target[w_idx];
        end
    end

    assign w_advance  = !rst && !redirect_valid && !stall;
    assign w_ras_push = w_advance && pred_taken && (w_type == CT_CALL);
    assign w_ras_pop  = w_advance && pred_taken && (w_type == CT_RET);

    ras_stack #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_ras_push),
        .push_addr (w_pc_plus4),
        .pop       (w_ras_pop),
        .top       (w_ras_top),
        .count     (w_ras_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= Zero;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (!stall) begin
            r_pc <= pred_target;
        end
    end

    always_comb begin
        w_uhit    = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
        w_new_ctr = upd_taken ? CTR_WT : CTR_WNT;
        if (w_uhit) begin
            if (upd_taken) begin
                w_new_ctr = (r_ctr[w_uidx] == CTR_MAX) ? CTR_MAX : r_ctr[w_uidx] + CTR_BITS'(1);
            end else begin
                w_new_ctr = (r_ctr[w_uidx] == '0) ? '0 : r_ctr[w_uidx] - CTR_BITS'(1);
            end
        end
    end

    // Tags and targets are never reset; an entry is meaningless until its valid bit is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= CTR_WNT;
            end
        end else if (upd_valid) begin
            r_valid[w_uidx]  <= 1'b1;
            r_tag[w_uidx]    <= w_utag;
            r_target[w_uidx] <= upd_target;
            r_type[w_uidx]   <= ctrl_type_e'(upd_type);
            r_ctr[w_uidx]    <= w_new_ctr;
        end
    end

    assign pc = r_pc;

endmodule

// File: tb/tb_pc_predictor.sv
// Self-checking bench for pc_predictor: directed scenarios plus random traffic against a queue/array model.
module tb_pc_predictor;

    localparam int IDXB = 7;
    localparam int TAGB = 9;
    localparam int CTRB = 2;
    localparam int RASD = 4;
    localparam int NENT = 1 << IDXB;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, upd_valid, upd_taken;
    logic [31:0] redirect_pc, upd_pc, upd_target;
    logic [1:0]  upd_type;
    logic [31:0] pc, pred_target;
    logic        pred_taken;

    pc_predictor #(
        .IDX_BITS  (IDXB),
        .TAG_BITS  (TAGB),
        .CTR_BITS  (CTRB),
        .RAS_DEPTH (RASD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .upd_type       (upd_type),
        .pc             (pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_init = 1'b0;
    bit          m_valid [NENT];
    int unsigned m_tag   [NENT];
    logic [31:0] m_tgt   [NENT];
    int          m_type  [NENT];
    int          m_ctr   [NENT];
    logic [31:0] m_ras   [$];
    logic [31:0] m_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a / 4) % NENT;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return (a / (4 * NENT)) % (1 << TAGB);
    endfunction

    task automatic model_predict(output bit tk, output logic [31:0] tgt, output int ty);
        int unsigned i = idx_of(m_pc);
        bit hit = m_valid[i] && (m_tag[i] == tag_of(m_pc));
        ty  = m_type[i];
        tk  = 1'b0;
        tgt = m_pc + 32'd4;
        if (hit) tk = (ty == 0) ? (m_ctr[i] >= (1 << (CTRB - 1))) : 1'b1;
        if (tk) tgt = (ty == 3 && m_ras.size() > 0) ? m_ras[$] : m_tgt[i];
    endtask

    task automatic step(input bit a_rst, input bit a_stall, input bit a_rv, input logic [31:0] a_rpc,
                        input bit a_uv, input logic [31:0] a_upc, input logic [31:0] a_utgt,
                        input bit a_utk, input logic [1:0] a_uty);
        bit          e_tk;
        logic [31:0] e_tgt;
        int          e_ty;
        int unsigned ui;
        rst = a_rst; stall = a_stall; redirect_valid = a_rv; redirect_pc = a_rpc;
        upd_valid = a_uv; upd_pc = a_upc; upd_target = a_utgt; upd_taken = a_utk; upd_type = a_uty;
        #1;
        model_predict(e_tk, e_tgt, e_ty);
        if (m_init) begin
            check("pc", pc, m_pc);
            check("pred_taken", {31'b0, pred_taken}, {31'b0, e_tk});
            check("pred_target", pred_target, e_tgt);
        end
        if (a_rst) begin
            m_init = 1'b1;
            m_pc   = 32'h0;
            m_ras.delete();
            for (int i = 0; i < NENT; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = (1 << (CTRB - 1)) - 1;
            end
        end else begin
            if (!a_rv && !a_stall && e_tk) begin
                if (e_ty == 2) begin
                    m_ras.push_back(m_pc + 32'd4);
                    if (m_ras.size() > RASD) void'(m_ras.pop_front());
                end else if (e_ty == 3 && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
            end
            if (a_rv) m_pc = a_rpc;
            else if (!a_stall) m_pc = e_tgt;
            if (a_uv) begin
                ui = idx_of(a_upc);
                if (m_valid[ui] && m_tag[ui] == tag_of(a_upc)) begin
                    if (a_utk) m_ctr[ui] = (m_ctr[ui] + 1 > (1 << CTRB) - 1) ? (1 << CTRB) - 1 : m_ctr[ui] + 1;
                    else       m_ctr[ui] = (m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1;
                end else begin
                    m_ctr[ui] = a_utk ? (1 << (CTRB - 1)) : (1 << (CTRB - 1)) - 1;
                end
                m_valid[ui] = 1'b1;
                m_tag[ui]   = tag_of(a_upc);
                m_tgt[ui]   = a_utgt;
                m_type[ui]  = int'(a_uty);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 2'b00);
    endtask

    task automatic redir(input logic [31:0] a);
        step(0, 0, 1, a, 0, 32'h0, 32'h0, 0, 2'b00);
    endtask

    task automatic upd(input logic [31:0] a, input logic [31:0] t, input bit tk, input logic [1:0] ty);
        step(0, 0, 0, 32'h0, 1, a, t, tk, ty);
    endtask

    logic [31:0] pool [12];
    logic [31:0] sites [5];
    logic [31:0] rets [5];

    initial begin
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0; upd_type = '0;
        pool  = '{32'h10, 32'h14, 32'h20, 32'h24, 32'h100, 32'h104, 32'h210, 32'h80,
                  32'h1010, 32'h3C, 32'hFFFF_FFFC, 32'h40};
        sites = '{32'h30, 32'h38, 32'h50, 32'h58, 32'h60};
        rets  = '{32'h64, 32'h5C, 32'h54, 32'h3C, 32'h0};
        @(negedge clk);

        step(1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 2'b00);
        step(1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            check("reset_seq_pc", pc, 32'(i * 4));
            check("reset_seq_taken", {31'b0, pred_taken}, 32'h0);
            idle();
        end

        upd(32'h10, 32'h40, 1, 2'b00);
        redir(32'h10);
        check("cond_alloc_taken", {31'b0, pred_taken}, 32'h1);
        check("cond_alloc_target", pred_target, 32'h40);
        upd(32'h10, 32'h40, 0, 2'b00);
        upd(32'h10, 32'h40, 0, 2'b00);
        redir(32'h10);
        check("cond_nt_taken", {31'b0, pred_taken}, 32'h0);
        check("cond_nt_target", pred_target, 32'h14);

        redir(32'h210);
        check("tag_miss_taken", {31'b0, pred_taken}, 32'h0);
        check("tag_miss_target", pred_target, 32'h214);

        upd(32'h20, 32'h100, 1, 2'b10);
        upd(32'h104, 32'h0, 1, 2'b11);
        redir(32'h20);
        check("call_target", pred_target, 32'h100);
        idle();
        check("call_pc", pc, 32'h100);
        idle();
        check("ret_target", pred_target, 32'h24);
        idle();
        check("ret_pc", pc, 32'h24);

        foreach (sites[k]) upd(sites[k], 32'h100, 1, 2'b10);
        foreach (sites[k]) begin
            redir(sites[k]);
            idle();
        end
        idle();
        for (int k = 0; k < 5; k++) begin
            check("nested_ret_target", pred_target, rets[k]);
            idle();
            if (k < 4) redir(32'h104);
        end

        step(0, 1, 1, 32'h80, 0, 32'h0, 32'h0, 0, 2'b00);
        check("redirect_over_stall", pc, 32'h80);
        step(0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 2'b00);
        check("stall_hold", pc, 32'h80);
        step(1, 0, 1, 32'h44, 1, 32'h80, 32'h200, 1, 2'b01);
        check("rst_over_all_pc", pc, 32'h0);
        redir(32'h80);
        check("rst_drops_update", {31'b0, pred_taken}, 32'h0);

        check("same_cycle_old", {31'b0, pred_taken}, 32'h0);
        upd(32'h80, 32'h300, 1, 2'b01);
        redir(32'h80);
        check("same_cycle_new_taken", {31'b0, pred_taken}, 32'h1);
        check("same_cycle_new_target", pred_target, 32'h300);

        redir(32'hFFFF_FFFC);
        check("wrap_target", pred_target, 32'h0);
        idle();
        check("wrap_pc", pc, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 150) == 0, ($urandom % 5) == 0, ($urandom % 8) == 0,
                 pool[$urandom_range(0, 11)], ($urandom % 3) == 0, pool[$urandom_range(0, 11)],
                 pool[$urandom_range(0, 11)], 1'($urandom % 2), 2'($urandom % 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
